ram_io_responder: RTL and testbench
===================================

Name: ram_io_responder

Overview:
- Target side of the memory controller's byte-wide RAM bus: one byte access per cycle, rw/addr/data driven by the controller.
- Contains the byte-addressed main RAM and a memory-mapped I/O window: a TX FIFO toward the UART, an RX byte port, and a halt register.
- Generates the io-buffer-full back-pressure the controller stalls on.
- Sits at top level between the memory controller and the host UART/simulation harness.

Parameters:
- RAM_AW, 17, RAM address width; RAM holds 2^RAM_AW bytes, indexed by iMC_addr[RAM_AW-1:0].
- TX_DEPTH, 8, TX FIFO entries (power of two, >=4).
- FULL_MARGIN, 2, free-slot margin at which oIO_buffer_full asserts.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low freezes all bus-side state.
- iMC_rw  in  1  1 = write, 0 = read.
- iMC_addr  in  32  byte address.
- iMC_dt  in  8  write data.
- oMC_dt  out  8  read data, registered, valid the cycle after the read.
- oIO_buffer_full  out  1  TX FIFO near-full back-pressure.
- oTX_valid  out  1  TX FIFO non-empty.
- oTX_dt  out  8  TX FIFO head byte.
- iTX_ready  in  1  host consumes head when high together with oTX_valid.
- iRX_valid  in  1  host input byte available.
- iRX_dt  in  8  host input byte.
- oRX_ack  out  1  one-cycle pulse, input byte consumed.
- oHalt  out  1  sticky, program-end written.
- oOverflow  out  1  sticky, TX push dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async): oMC_dt=0, FIFO rd/wr pointers and count=0, oTX_valid=0, oTX_dt=0, oRX_ack=0, oHalt=0, oOverflow=0, oIO_buffer_full=0. RAM contents are not reset. Reset mid-transfer discards FIFO contents and any in-flight read.
- Decode: IO region when iMC_addr[17:16]==2'b11. Otherwise RAM at iMC_addr[RAM_AW-1:0]; higher address bits are ignored (aliasing).
- All bus-side actions happen only on rising edges with rdy=1. With rdy=0: no RAM write, no FIFO push, no RX pop, oMC_dt holds, oRX_ack=0.
- RAM read (rw=0): oMC_dt <= mem[addr] at the edge; 1-cycle latency. Back-to-back reads return one byte per cycle.
- RAM write (rw=1): mem[addr] <= iMC_dt at the edge; oMC_dt <= 0.
- A read of an address written the previous cycle returns the new value.
- IO write 0x30000: push iMC_dt into the TX FIFO.
  - Push is accepted if count < TX_DEPTH, or if a pop occurs at the same edge (full with simultaneous push+pop: both happen, count unchanged).
  - Otherwise the byte is dropped and oOverflow <= 1.
- IO write 0x30004: oHalt <= 1. Other IO writes have no effect.
- IO read 0x30000:
  - iRX_valid=1: oMC_dt <= iRX_dt and oRX_ack pulses high for exactly the following cycle.
  - iRX_valid=0: oMC_dt <= 0, no ack.
- IO read 0x30004: oMC_dt <= {7'b0, (count==0)}. Other IO reads: oMC_dt <= 0.
- TX drain is independent of rdy:
  - oTX_valid = (count != 0); oTX_dt = entry at rd pointer.
  - A pop at each edge where oTX_valid && iTX_ready.
  - Pointers wrap modulo TX_DEPTH; count is log2(TX_DEPTH)+1 bits.
- oIO_buffer_full = (count >= TX_DEPTH - FULL_MARGIN), combinational from registered count. The margin covers the controller's reaction latency, so no drops occur in normal operation.
- oHalt and oOverflow stay set until reset.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> oMC_dt=0xA5 one cycle after the read edge; write cycle leaves oMC_dt=0.
- Write 0x11 to 0x1FFFF and 0x22 to 0x00000 back-to-back, then read both -> 0x11, then 0x22; 0x2FFFF aliases 0x0FFFF, not 0x1FFFF.
- iTX_ready=0, push 8 bytes 0x01..0x08 to 0x30000 -> oIO_buffer_full rises after the 6th push; 9th push dropped, oOverflow=1; then iTX_ready=1 -> oTX_dt sequence 0x01..0x08, oTX_valid=0 after 8 pops.
- FIFO full with iTX_ready=1, push 0x09 at the same edge -> accepted, count stays 8, oOverflow stays 0, 0x09 emerges last.
- iRX_valid=1, iRX_dt=0x41, read 0x30000 -> oMC_dt=0x41 and oRX_ack high one cycle; with iRX_valid=0 -> oMC_dt=0, no ack. Read 0x30004 with empty FIFO -> 0x01.
- rdy=0 during a write to 0x30004 -> oHalt stays 0; then rdy=1 -> oHalt=1. Assert rst low mid-drain -> oTX_valid=0 immediately, oHalt=0.

Source files
------------

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide RAM bus target with main RAM, TX FIFO, RX port and halt register.
module ram_io_responder #(
   parameter int RAM_AW      = 17,
   parameter int TX_DEPTH    = 8,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        iMC_rw,
   input  logic [31:0] iMC_addr,
   input  logic [7:0]  iMC_dt,
   output logic [7:0]  oMC_dt,
   output logic        oIO_buffer_full,
   output logic        oTX_valid,
   output logic [7:0]  oTX_dt,
   input  logic        iTX_ready,
   input  logic        iRX_valid,
   input  logic [7:0]  iRX_dt,
   output logic        oRX_ack,
   output logic        oHalt,
   output logic        oOverflow
);
   localparam int PW = $clog2(TX_DEPTH);
   localparam logic [PW:0] DEPTH = (PW+1)'(TX_DEPTH);
   localparam logic [PW:0] NEAR_FULL = (PW+1)'(TX_DEPTH - FULL_MARGIN);
   localparam logic [31:0] TX_ADDR = 32'h0003_0000;
   localparam logic [31:0] CTRL_ADDR = 32'h0003_0004;
   logic [7:0]    mem [2**RAM_AW];
   logic [7:0]    fifo [TX_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          io, tx_sel, ctrl_sel, pop, push_req, push;
   always_comb begin
      io       = iMC_addr[17:16] == 2'b11;
      tx_sel   = iMC_addr == TX_ADDR;
      ctrl_sel = iMC_addr == CTRL_ADDR;
      pop      = oTX_valid && iTX_ready;
      push_req = rdy && iMC_rw && tx_sel;
      // a full FIFO still accepts a push when the head leaves at the same edge
      push     = push_req && (count < DEPTH || pop);
   end
   assign oTX_valid       = count != '0;
   assign oTX_dt          = fifo[rd_ptr];
   assign oIO_buffer_full = count >= NEAR_FULL;
   always_ff @(posedge clk)
      if (rdy && iMC_rw && !io) mem[iMC_addr[RAM_AW-1:0]] <= iMC_dt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         oMC_dt    <= '0;
         oRX_ack   <= 1'b0;
         oHalt     <= 1'b0;
         oOverflow <= 1'b0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         for (int i = 0; i < TX_DEPTH; i++) fifo[i] <= '0;
      end else begin
         if (rdy)
            oMC_dt <= iMC_rw ? 8'h00 :
                      !io ? mem[iMC_addr[RAM_AW-1:0]] :
                      tx_sel ? (iRX_valid ? iRX_dt : 8'h00) :
                      ctrl_sel ? {7'b0, count == '0} : 8'h00;
         oRX_ack   <= rdy && !iMC_rw && tx_sel && iRX_valid;
         oHalt     <= oHalt | (rdy && iMC_rw && ctrl_sel);
         oOverflow <= oOverflow | (push_req && !push);
         if (push) begin
            fifo[wr_ptr] <= iMC_dt;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed self-checking bench for ram_io_responder.
module tb_ram_io_responder;
   logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0, iMC_rw = 1'b0;
   logic [31:0] iMC_addr = '0;
   logic [7:0]  iMC_dt = '0, oMC_dt, oTX_dt, iRX_dt = '0;
   logic        oIO_buffer_full, oTX_valid, iTX_ready = 1'b0, iRX_valid = 1'b0;
   logic        oRX_ack, oHalt, oOverflow;
   int          checks = 0, errors = 0;

   ram_io_responder dut (
      .clk(clk), .rst(rst), .rdy(rdy), .iMC_rw(iMC_rw), .iMC_addr(iMC_addr),
      .iMC_dt(iMC_dt), .oMC_dt(oMC_dt), .oIO_buffer_full(oIO_buffer_full),
      .oTX_valid(oTX_valid), .oTX_dt(oTX_dt), .iTX_ready(iTX_ready),
      .iRX_valid(iRX_valid), .iRX_dt(iRX_dt), .oRX_ack(oRX_ack),
      .oHalt(oHalt), .oOverflow(oOverflow)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic rw, input logic [31:0] a, input logic [7:0] d);
      rdy = 1'b1; iMC_rw = rw; iMC_addr = a; iMC_dt = d;
   endtask

   task automatic apply_reset;
      #2 rst = 1'b0;
      #2 rst = 1'b1;
      rdy = 1'b0; iTX_ready = 1'b0; iRX_valid = 1'b0;
      tick;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (oMC_dt !== 8'h00) begin errors++; $display("FAIL reset_mc_dt: got %h exp 00", oMC_dt); end
      checks++; if (oTX_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b exp 0", oTX_valid); end
      checks++; if (oTX_dt !== 8'h00) begin errors++; $display("FAIL reset_tx_dt: got %h exp 00", oTX_dt); end
      checks++; if ({oRX_ack, oHalt, oOverflow, oIO_buffer_full} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b exp 0000", {oRX_ack, oHalt, oOverflow, oIO_buffer_full}); end
      #2 rst = 1'b1;
      tick;
   endtask

   task automatic test_ram_rw;
      bus(1, 32'h10, 8'hA5); tick;
      checks++; if (oMC_dt !== 8'h00) begin errors++; $display("FAIL write_clears_dt: got %h exp 00", oMC_dt); end
      bus(0, 32'h10, 8'h00); tick;
      checks++; if (oMC_dt !== 8'hA5) begin errors++; $display("FAIL read_a5: got %h exp a5", oMC_dt); end
   endtask

   task automatic test_alias;
      bus(1, 32'h1FFFF, 8'h11); tick;
      bus(1, 32'h00000, 8'h22); tick;
      bus(1, 32'h0FFFF, 8'h33); tick;
      bus(0, 32'h1FFFF, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h11) begin errors++; $display("FAIL read_1ffff: got %h exp 11", oMC_dt); end
      bus(0, 32'h00000, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h22) begin errors++; $display("FAIL read_00000: got %h exp 22", oMC_dt); end
      bus(0, 32'h2FFFF, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h33) begin errors++; $display("FAIL alias_2ffff: got %h exp 33", oMC_dt); end
   endtask

   task automatic test_fifo_fill;
      apply_reset;
      for (int i = 1; i <= 8; i++) begin
         bus(1, 32'h30000, 8'(i)); tick;
         checks++; if (oIO_buffer_full !== (i >= 6)) begin
            errors++; $display("FAIL buffer_full_push%0d: got %b exp %b", i, oIO_buffer_full, i >= 6); end
      end
      checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b exp 0", oOverflow); end
      bus(1, 32'h30000, 8'h09); tick;
      checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL overflow_drop: got %b exp 1", oOverflow); end
      rdy = 1'b0; iTX_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         checks++; if (oTX_valid !== 1'b1 || oTX_dt !== 8'(i)) begin
            errors++; $display("FAIL drain%0d: got v=%b %h exp v=1 %h", i, oTX_valid, oTX_dt, 8'(i)); end
         tick;
      end
      checks++; if (oTX_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b exp 0", oTX_valid); end
   endtask

   task automatic test_full_push_pop;
      apply_reset;
      for (int i = 1; i <= 8; i++) begin bus(1, 32'h30000, 8'(i)); tick; end
      iTX_ready = 1'b1;
      bus(1, 32'h30000, 8'h09); tick;
      checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b exp 0", oOverflow); end
      checks++; if (oIO_buffer_full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b exp 1", oIO_buffer_full); end
      rdy = 1'b0;
      for (int i = 2; i <= 9; i++) begin
         checks++; if (oTX_valid !== 1'b1 || oTX_dt !== 8'(i)) begin
            errors++; $display("FAIL pushpop_drain%0d: got v=%b %h exp v=1 %h", i, oTX_valid, oTX_dt, 8'(i)); end
         tick;
      end
      checks++; if (oTX_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b exp 0", oTX_valid); end
      iTX_ready = 1'b0;
   endtask

   task automatic test_rx;
      iRX_valid = 1'b1; iRX_dt = 8'h41;
      bus(0, 32'h30000, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h41 || oRX_ack !== 1'b1) begin
         errors++; $display("FAIL rx_read: got %h ack=%b exp 41 ack=1", oMC_dt, oRX_ack); end
      rdy = 1'b0; tick;
      checks++; if (oMC_dt !== 8'h41 || oRX_ack !== 1'b0) begin
         errors++; $display("FAIL rx_hold: got %h ack=%b exp 41 ack=0", oMC_dt, oRX_ack); end
      iRX_valid = 1'b0;
      bus(0, 32'h30000, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h00 || oRX_ack !== 1'b0) begin
         errors++; $display("FAIL rx_empty: got %h ack=%b exp 00 ack=0", oMC_dt, oRX_ack); end
      bus(0, 32'h30004, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h01) begin errors++; $display("FAIL status_empty: got %h exp 01", oMC_dt); end
   endtask

   task automatic test_halt_and_reset;
      bus(1, 32'h30004, 8'h00); rdy = 1'b0; tick;
      checks++; if (oHalt !== 1'b0) begin errors++; $display("FAIL halt_rdy_low: got %b exp 0", oHalt); end
      rdy = 1'b1; tick;
      checks++; if (oHalt !== 1'b1) begin errors++; $display("FAIL halt_set: got %b exp 1", oHalt); end
      for (int i = 0; i < 3; i++) begin bus(1, 32'h30000, 8'(8'hC0 + i)); tick; end
      bus(0, 32'h30004, 8'h00); tick;
      checks++; if (oMC_dt !== 8'h00) begin errors++; $display("FAIL status_nonempty: got %h exp 00", oMC_dt); end
      rdy = 1'b0; iTX_ready = 1'b1; tick;
      checks++; if (oTX_valid !== 1'b1 || oTX_dt !== 8'hC1) begin
         errors++; $display("FAIL mid_drain: got v=%b %h exp v=1 c1", oTX_valid, oTX_dt); end
      #2 rst = 1'b0;
      #1;
      checks++; if (oTX_valid !== 1'b0 || oHalt !== 1'b0 || oMC_dt !== 8'h00) begin
         errors++; $display("FAIL async_reset: got v=%b halt=%b dt=%h exp 0 0 00", oTX_valid, oHalt, oMC_dt); end
      #2 rst = 1'b1;
      iTX_ready = 1'b0;
   endtask

   initial begin
      test_reset;
      test_ram_rw;
      test_alias;
      test_fifo_fill;
      test_full_push_pop;
      test_rx;
      test_halt_and_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
